// File: rtl/mult_seq_ctrl_pkg.sv
// mult_seq_ctrl_pkg: shared FSM states, default operand width and counter sizing
package mult_seq_ctrl_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if: core-side request, HI/LO write port and result/status bundle
interface mult_seq_ctrl_if
    import mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             hi_we_i;
    logic             lo_we_i;
    logic [WIDTH-1:0] wdata_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, signed_i, src1_i, src2_i, hi_we_i, lo_we_i, wdata_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, signed_i, src1_i, src2_i, hi_we_i, lo_we_i, wdata_i,
        output busy_o, done_o, hi_o, lo_o
    );

endinterface

// File: rtl/mult_shift_add_dp.sv
// mult_shift_add_dp: magnitude shift-add product register with final sign fix-up
module mult_shift_add_dp
    import mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               fix_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   src1_i,
    input  logic [WIDTH-1:0]   src2_i,
    output logic [2*WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] mcand_q, mcand_d, mplr_d;
    logic [2*WIDTH:0] prod_q, prod_d;
    logic             neg_q, neg_d;
    logic [WIDTH:0]   sum;

    // prod_q = {acc[WIDTH:0], mplr[WIDTH-1:0]}; acc top bit is always 0 after a shift
    always_comb begin
        sum      = prod_q[2*WIDTH:WIDTH] + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mplr_d   = (signed_i & src2_i[WIDTH-1]) ? -src2_i : src2_i;
        mcand_d  = load_i ? ((signed_i & src1_i[WIDTH-1]) ? -src1_i : src1_i)
                          : (fix_i ? '0 : mcand_q);
        neg_d    = load_i ? (signed_i & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]))
                          : (fix_i ? 1'b0 : neg_q);
        prod_d   = load_i ? {{(WIDTH+1){1'b0}}, mplr_d}
                 : step_i ? {1'b0, sum, prod_q[WIDTH-1:1]}
                 : fix_i  ? '0 : prod_q;
        result_o = neg_q ? -prod_q[2*WIDTH-1:0] : prod_q[2*WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: iterative mult/multu sequencer owning HI/LO, stall and done signalling
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic          clk_i,
    input logic          rst_i,
    mult_seq_ctrl_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               open, load, step, fix;
    logic [2*WIDTH-1:0] result;

    // IDLE and DONE both accept new work and mthi/mtlo writes
    always_comb begin
        open    = (state_q == IDLE) || (state_q == DONE);
        load    = open & bus.start_i;
        step    = state_q == CALC;
        fix     = state_q == FIX;
        state_d = load              ? CALC
                : state_q == DONE   ? IDLE
                : step              ? ((cnt_q == '0) ? FIX : CALC)
                : fix               ? DONE : state_q;
        cnt_d   = load ? CW'(WIDTH-1) : step ? cnt_q - CW'(1) : cnt_q;
        hi_d    = fix ? result[2*WIDTH-1:WIDTH] : (open & bus.hi_we_i) ? bus.wdata_i : hi_q;
        lo_d    = fix ? result[WIDTH-1:0]       : (open & bus.lo_we_i) ? bus.wdata_i : lo_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load),
        .step_i   (step),
        .fix_i    (fix),
        .signed_i (bus.signed_i),
        .src1_i   (bus.src1_i),
        .src2_i   (bus.src2_i),
        .result_o (result)
    );

    assign bus.busy_o = step | fix;
    assign bus.done_o = state_q == DONE;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: randomized and directed checks of mult_seq_ctrl against a 64-bit product model
module tb_mult_seq_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] exp_hi, exp_lo;

    mult_seq_ctrl_if #(.WIDTH(32)) bus ();

    mult_seq_ctrl #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        return s ? 64'(sa * sb) : 64'(ua * ub);
    endfunction

    // Issue one multiply; re-assert start with 9x9 at the given busy cycles to test that it is ignored.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int again1, input int again2);
        int          n, nb;
        logic [63:0] p;
        bus.start_i  = 1'b1;
        bus.signed_i = s;
        bus.src1_i   = a;
        bus.src2_i   = b;
        @(negedge clk);
        p = ref_prod(a, b, s);
        bus.start_i  = 1'b0;
        bus.src1_i   = $urandom;
        bus.src2_i   = $urandom;
        bus.signed_i = 1'($urandom);
        check("busy_rise", {63'b0, bus.busy_o}, 64'd1);
        n  = 0;
        nb = 0;
        while (!bus.done_o && n < 60) begin
            if (bus.busy_o) nb++;
            bus.start_i = (n == again1) || (n == again2);
            if (bus.start_i) begin
                bus.src1_i = 32'd9;
                bus.src2_i = 32'd9;
            end
            @(negedge clk);
            n++;
        end
        bus.start_i = 1'b0;
        check("latency", 64'(n), 64'd33);
        check("busy_cycles", 64'(nb), 64'd33);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        check("hi", {32'b0, bus.hi_o}, {32'b0, exp_hi});
        check("lo", {32'b0, bus.lo_o}, {32'b0, exp_lo});
    endtask

    task automatic idle_after_done();
        @(negedge clk);
        check("done_width", {63'b0, bus.done_o}, 64'd0);
        check("busy_idle", {63'b0, bus.busy_o}, 64'd0);
    endtask

    task automatic write_hl(input logic hi, input logic [31:0] d);
        bus.hi_we_i = hi;
        bus.lo_we_i = ~hi;
        bus.wdata_i = d;
        @(negedge clk);
        bus.hi_we_i = 1'b0;
        bus.lo_we_i = 1'b0;
        if (hi) exp_hi = d;
        else    exp_lo = d;
        check(hi ? "mthi" : "mtlo", {bus.hi_o, bus.lo_o}, {exp_hi, exp_lo});
    endtask

    initial begin
        int          dn;
        logic [31:0] a, b;
        logic [31:0] corner [4];
        checks = 0;
        errors = 0;
        corner[0] = 32'h0;
        corner[1] = 32'h1;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'hFFFF_FFFF;
        rst = 1'b0;
        bus.start_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.src1_i   = '0;
        bus.src2_i   = '0;
        bus.hi_we_i  = 1'b0;
        bus.lo_we_i  = 1'b0;
        bus.wdata_i  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        check("reset_status", {62'b0, bus.busy_o, bus.done_o}, 64'd0);
        check("reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);

        write_hl(1'b1, 32'h1234_5678);

        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, -1);
        check("umax", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFE_0000_0001);
        idle_after_done();
        do_mul(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, -1, -1);
        check("neg3x5", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
        idle_after_done();
        do_mul(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1);
        check("min_x_m1", {bus.hi_o, bus.lo_o}, 64'h0000_0000_8000_0000);
        idle_after_done();
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, -1, -1);
        check("min_x_min", {bus.hi_o, bus.lo_o}, 64'h4000_0000_0000_0000);
        idle_after_done();

        do_mul(32'd7, 32'd6, 1'b0, 3, 20);
        check("ignored_start", {bus.hi_o, bus.lo_o}, 64'd42);
        do_mul(32'd2, 32'd3, 1'b0, -1, -1);
        check("b2b", {bus.hi_o, bus.lo_o}, 64'd6);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o) dn++;
        end
        check("no_extra_done", 64'(dn), 64'd0);

        write_hl(1'b1, 32'hAAAA_5555);
        write_hl(1'b0, 32'h0000_1234);
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        check("glitch_rst", {bus.hi_o, bus.lo_o}, {exp_hi, exp_lo});

        bus.start_i  = 1'b1;
        bus.signed_i = 1'b0;
        bus.src1_i   = 32'd5;
        bus.src2_i   = 32'd5;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        check("rst_busy", {63'b0, bus.busy_o}, 64'd0);
        check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) dn++;
        end
        check("rst_no_done", 64'(dn), 64'd0);

        bus.start_i  = 1'b1;
        bus.signed_i = 1'b0;
        bus.src1_i   = 32'd100;
        bus.src2_i   = 32'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        bus.lo_we_i = 1'b1;
        bus.wdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.lo_we_i = 1'b0;
        check("mtlo_in_calc", {32'b0, bus.lo_o}, 64'd0);
        dn = 0;
        while (!bus.done_o && dn < 60) begin
            @(negedge clk);
            dn++;
        end
        check("calc_write_done", {63'b0, bus.done_o}, 64'd1);
        check("mtlo_overwritten", {bus.hi_o, bus.lo_o}, 64'd300);
        idle_after_done();

        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : 32'($urandom);
            b = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : 32'($urandom);
            do_mul(a, b, 1'($urandom), -1, -1);
            if ($urandom_range(1) == 1) idle_after_done();
            if ($urandom_range(2) == 0) write_hl(1'($urandom), 32'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
